// File: rtl/uart_pkg.sv
// uart_pkg: shared register map, STATUS bit positions and drain FSM states for uart_mmio_bridge
package uart_pkg;
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam int ST_RX_NE   = 0;
  localparam int ST_TX_FULL = 1;
  localparam int ST_TX_IDLE = 2;
  localparam int ST_RX_OVR  = 3;
  localparam int ST_TX_OVF  = 4;
  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} drain_t;
endpackage

// File: rtl/uart_mmio_bridge_if.sv
// uart_mmio_bridge_if: CPU data bus between master and bridge
//   sel/we/addr/wdata  master -> slave, access request held until ready
//   rdata/ready        slave -> master, one-cycle completion with read data
interface uart_mmio_bridge_if;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  modport master(output sel, we, addr, wdata, input rdata, ready);
  modport slave(input sel, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational head and occupancy count
//   push/din   write side; accepted when not full, or when a pop happens the same cycle
//   pop/dout   read side; dout is the head, pop ignored when empty
//   full/empty/count  occupancy, count saturates at DEPTH
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= do_push ? wp + AW'(1) : wp;
      rp <= do_pop ? rp + AW'(1) : rp;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/uart_mmio_bridge.sv
// uart_mmio_bridge: memory-mapped DATA/STATUS/CTRL front end buffering bytes between CPU bus and UART
//   clk, rst_n        clock, asynchronous active-low reset
//   bus               slave side of uart_mmio_bridge_if (1-cycle latency, registered rdata)
//   tx_data/tx_start  byte and one-cycle start pulse to UART; tx_busy back from UART
//   rx_valid/rx_data  received-byte pulse from UART
//   irq               registered interrupt, only with UART_IRQ_EN defined (else tied 0, CTRL absent)
module uart_mmio_bridge
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_mmio_bridge_if.slave bus,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              irq
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  drain_t state, state_nx;
  logic acc, wr, rd, tx_push, tx_pop, rx_pop;
  logic tx_full, tx_empty, rx_full, rx_empty, tx_idle, rx_ovr, tx_ovf, st_wr;
  logic [7:0] tx_head, rx_head;
  logic [CNT_W-1:0] tx_count, rx_count;
  logic [1:0] ctrl;
  logic [31:0] status, rd_word;
  logic unused;
  assign acc = bus.sel & ~bus.ready;
  assign wr = acc & bus.we;
  assign rd = acc & ~bus.we;
  assign tx_push = wr && bus.addr == ADDR_DATA;
  assign rx_pop = rd && bus.addr == ADDR_DATA;
  assign st_wr = wr && bus.addr == ADDR_STATUS;
  assign tx_idle = tx_empty && state == IDLE && !tx_busy;
  assign unused = ^{bus.wdata[31:8], tx_count};
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_push), .pop(tx_pop), .din(bus.wdata[7:0]),
    .dout(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(rx_valid), .pop(rx_pop), .din(rx_data),
    .dout(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );
  always_comb begin
    tx_pop = state == IDLE && !tx_empty && !tx_busy;
    state_nx = tx_pop ? WAIT_BUSY :
               (state == WAIT_BUSY && tx_busy) ? WAIT_DONE :
               (state == WAIT_DONE && !tx_busy) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    status = '0;
    status[ST_RX_NE] = ~rx_empty;
    status[ST_TX_FULL] = tx_full;
    status[ST_TX_IDLE] = tx_idle;
    status[ST_RX_OVR] = rx_ovr;
    status[ST_TX_OVF] = tx_ovf;
    status[15:8] = 8'(rx_count);
    rd_word = bus.addr == ADDR_DATA ? (rx_empty ? '0 : {24'b0, rx_head}) :
              bus.addr == ADDR_STATUS ? status :
              bus.addr == ADDR_CTRL ? {30'b0, ctrl} : '0;
  end
  // Full implies non-empty, so the raw pop request tells whether a slot frees up this cycle.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_start <= 1'b0;
      tx_data <= '0;
      rx_ovr <= 1'b0;
      tx_ovf <= 1'b0;
      bus.ready <= 1'b0;
      bus.rdata <= '0;
    end else begin
      tx_start <= tx_pop;
      tx_data <= tx_pop ? tx_head : tx_data;
      rx_ovr <= (rx_valid & rx_full & ~rx_pop) | (rx_ovr & ~(st_wr & bus.wdata[ST_RX_OVR]));
      tx_ovf <= (tx_push & tx_full & ~tx_pop) | (tx_ovf & ~(st_wr & bus.wdata[ST_TX_OVF]));
      bus.ready <= acc;
      bus.rdata <= rd ? rd_word : '0;
    end
`ifdef UART_IRQ_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ctrl <= '0;
      irq <= 1'b0;
    end else begin
      ctrl <= (wr && bus.addr == ADDR_CTRL) ? bus.wdata[1:0] : ctrl;
      irq <= (ctrl[0] & ~rx_empty) | (ctrl[1] & tx_idle);
    end
`else
  assign ctrl = '0;
  assign irq = 1'b0;
`endif
endmodule
